// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the 4x4 matrix scanner.
// The master modport is the scanner; the slave is the keypad/consumer side.
`timescale 1ns/1ps
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one active-low column at a time, debounces
// press and release of a single key and reports its {col,row} code.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [3:0]      r_sync1;
  logic [3:0]      r_rows_s;
  logic [1:0]      r_col_idx;
  logic [SW-1:0]   r_scan_cnt;
  logic [DW-1:0]   r_deb_cnt;
  logic [1:0]      r_col_lat;
  logic [1:0]      r_row_lat;
  logic [3:0]      r_col_n;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;

  logic [1:0]      w_low_row;
  logic [1:0]      w_col_inc;
  logic [3:0]      w_col_n_inc;
  logic            w_lat_row;

  // Lowest-index low row wins when several rows of the column are pressed.
  always_comb begin
    w_low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rows_s[i]) begin
        w_low_row = 2'(i);
      end
    end
  end

  assign w_col_inc   = r_col_idx + 2'd1;
  assign w_col_n_inc = ~(4'b0001 << w_col_inc);
  assign w_lat_row   = r_rows_s[r_row_lat];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_sync1     <= 4'hF;
      r_rows_s    <= 4'hF;
      r_col_idx   <= 2'd0;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_col_lat   <= 2'd0;
      r_row_lat   <= 2'd0;
      r_col_n     <= 4'b1110;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= kp.row_n;
      r_rows_s    <= r_sync1;
      r_key_valid <= 1'b0;

      case (r_state)
        SCAN: begin
          if (r_scan_cnt == SCAN_LAST) begin
            if (r_rows_s != 4'hF) begin
              r_col_lat <= r_col_idx;
              r_row_lat <= w_low_row;
              r_deb_cnt <= '0;
              r_state   <= DEBOUNCE;
            end else begin
              r_col_idx  <= w_col_inc;
              r_col_n    <= w_col_n_inc;
              r_scan_cnt <= '0;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
          end
        end

        DEBOUNCE: begin
          if (w_lat_row) begin
            r_col_idx  <= w_col_inc;
            r_col_n    <= w_col_n_inc;
            r_scan_cnt <= '0;
            r_state    <= SCAN;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_key_code  <= {r_col_lat, r_row_lat};
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= PRESSED;
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end

        PRESSED: begin
          if (w_lat_row) begin
            r_deb_cnt <= '0;
            r_state   <= RELEASE;
          end
        end

        RELEASE: begin
          // A re-press before the release settles resumes the same hold silently.
          if (!w_lat_row) begin
            r_state <= PRESSED;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_key_held <= 1'b0;
            r_col_idx  <= w_col_inc;
            r_col_n    <= w_col_n_inc;
            r_scan_cnt <= '0;
            r_state    <= SCAN;
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign kp.col_n     = r_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad matrix.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int SC = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // pressed[c][r]: key at column c, row r is held down
  logic [3:0] pressed [4];
  logic [3:0] w_row_n;

  always_comb begin
    w_row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[c][r] && !kp.col_n[c]) w_row_n[r] = 1'b0;
      end
    end
  end
  assign kp.row_n = w_row_n;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic release_all();
    for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
  endtask

  // Advance n cycles, counting key_valid pulses and remembering the last code.
  task automatic run_count(input int n, output int pulses, output logic [3:0] code);
    pulses = 0;
    code   = 4'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (kp.key_valid) begin
        pulses++;
        code = kp.key_code;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset col_n", kp.col_n, 4'b1110);
    check("reset key_code", kp.key_code, 0);
    check("reset key_valid", kp.key_valid, 0);
    check("reset key_held", kp.key_held, 0);
    rst = 1'b0;
  endtask

  // Invariants: one-hot-low column drive and single-cycle key_valid pulses.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      check("col_n one-hot-low", int'(kp.col_n == 4'b1110 || kp.col_n == 4'b1101 ||
                                      kp.col_n == 4'b1011 || kp.col_n == 4'b0111), 1);
      if (kp.key_valid) check("key_valid single cycle", prev_valid, 0);
      prev_valid = kp.key_valid;
    end
  end

  typedef struct {
    int         k;        // cycles after reset release
    logic [15:0] keys;    // {col3..col0} pressed-row masks applied
    logic [3:0] col_n;
    logic       valid;
    logic       held;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int         pulses;
    int         lat;
    int         cur;
    int         changes;
    logic [3:0] code;
    logic [3:0] last_col;
    logic [3:0] model_code;
    bit         found;

    vecs[0] = '{1,  16'h0, 4'b1110, 1'b0, 1'b0};
    vecs[1] = '{3,  16'h0, 4'b1110, 1'b0, 1'b0};
    vecs[2] = '{4,  16'h0, 4'b1101, 1'b0, 1'b0};
    vecs[3] = '{7,  16'h0, 4'b1101, 1'b0, 1'b0};
    vecs[4] = '{8,  16'h0, 4'b1011, 1'b0, 1'b0};
    vecs[5] = '{11, 16'h0, 4'b1011, 1'b0, 1'b0};
    vecs[6] = '{12, 16'h0, 4'b0111, 1'b0, 1'b0};
    vecs[7] = '{15, 16'h0, 4'b0111, 1'b0, 1'b0};
    vecs[8] = '{16, 16'h0, 4'b1110, 1'b0, 1'b0};
    vecs[9] = '{19, 16'h0, 4'b1110, 1'b0, 1'b0};

    release_all();

    // 1. reset
    @(negedge clk);
    do_reset();

    // 2. idle column stepping
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) pressed[c] = vecs[i].keys[c*4 +: 4];
      repeat (vecs[i].k - cur) @(negedge clk);
      cur = vecs[i].k;
      $display("idle vec %0d: cycle %0d col_n=%b", i, cur, kp.col_n);
      check("idle col_n", kp.col_n, vecs[i].col_n);
      check("idle key_valid", kp.key_valid, vecs[i].valid);
      check("idle key_held", kp.key_held, vecs[i].held);
    end

    // 3. press (col2,row1) for 200 cycles
    pressed[2][1] = 1'b1;
    lat = 0;
    found = 1'b0;
    while (!found && lat < 40) begin
      @(negedge clk);
      lat++;
      if (kp.key_valid) found = 1'b1;
    end
    check("press accepted in time", int'(found), 1);
    check("press latency in window", int'(lat >= 2 + DC + 1 && lat <= 2 + 4*SC + DC + 2), 1);
    check("press key_code", kp.key_code, 4'b1001);
    run_count(200 - lat, pulses, code);
    $display("press c2r1: latency=%0d extra pulses=%0d held=%b", lat, pulses, kp.key_held);
    check("press single pulse", pulses, 0);
    check("press held", kp.key_held, 1);
    release_all();
    repeat (2 + 1 + DC - 1) @(negedge clk);
    check("held until release debounced", kp.key_held, 1);
    @(negedge clk);
    check("held drops after release", kp.key_held, 0);
    check("key_code kept after release", kp.key_code, 4'b1001);

    // 4. bounce on (col1,row3) aligned to the start of column 1's slot
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (kp.col_n == 4'b1101) found = 1'b1;
    end
    check("reach column 1", int'(found), 1);
    pressed[1][3] = 1'b1;
    run_count(3, pulses, code);
    release_all();
    changes = 0;
    last_col = kp.col_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kp.key_valid) pulses++;
      if (kp.col_n != last_col) changes++;
      last_col = kp.col_n;
    end
    $display("bounce c1r3: pulses=%0d column changes=%0d", pulses, changes);
    check("bounce no pulse", pulses, 0);
    check("bounce held low", kp.key_held, 0);
    check("bounce scanning resumes", int'(changes >= 4), 1);

    // 5. two keys in column 3, then a short release glitch
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    run_count(100, pulses, code);
    $display("dual c3r0+c3r2: pulses=%0d code=%b", pulses, code);
    check("dual one pulse", pulses, 1);
    check("dual key_code", kp.key_code, 4'b1100);
    check("dual held", kp.key_held, 1);
    release_all();
    run_count(4, pulses, code);
    pressed[3][0] = 1'b1;
    pressed[3][2] = 1'b1;
    check("glitch held through", kp.key_held, 1);
    run_count(60, pulses, code);
    $display("glitch: pulses=%0d held=%b", pulses, kp.key_held);
    check("glitch no second pulse", pulses, 0);
    check("glitch held after", kp.key_held, 1);
    release_all();
    run_count(30, pulses, code);
    check("dual released", kp.key_held, 0);

    // 6. reset during PRESSED
    pressed[2][1] = 1'b1;
    run_count(100, pulses, code);
    check("pre-reset pulse", pulses, 1);
    check("pre-reset held", kp.key_held, 1);
    rst = 1'b1;
    @(negedge clk);
    $display("reset in PRESSED: col_n=%b held=%b code=%b", kp.col_n, kp.key_held, kp.key_code);
    check("mid reset col_n", kp.col_n, 4'b1110);
    check("mid reset key_held", kp.key_held, 0);
    check("mid reset key_code", kp.key_code, 0);
    check("mid reset key_valid", kp.key_valid, 0);
    release_all();
    rst = 1'b0;
    run_count(40, pulses, code);
    check("no pulse after reset", pulses, 0);

    // Random single/same-column-pair presses against a transaction-level model.
    model_code = 4'h0;
    for (int it = 0; it < 20; it++) begin
      int  c, r, r2, hold, exp_pulses, p2;
      bit  two, long_hold;
      logic [1:0] lowest;
      repeat ($urandom_range(0, 15)) @(negedge clk);
      c         = $urandom_range(0, 3);
      r         = $urandom_range(0, 3);
      r2        = $urandom_range(0, 3);
      two       = 1'($urandom_range(0, 1));
      long_hold = 1'($urandom_range(0, 1));
      hold      = long_hold ? 60 + $urandom_range(0, 40) : 1 + $urandom_range(0, 2);
      pressed[c][r] = 1'b1;
      if (two) pressed[c][r2] = 1'b1;
      lowest = 2'((two && r2 < r) ? r2 : r);
      exp_pulses = long_hold ? 1 : 0;
      if (long_hold) model_code = {2'(c), lowest};
      run_count(hold, pulses, code);
      if (long_hold) check("rand held while pressed", kp.key_held, 1);
      release_all();
      run_count(30, p2, code);
      pulses += p2;
      $display("rand %0d: key c%0d r%0d%s hold=%0d pulses=%0d code=%b", it, c, r,
               two ? $sformatf("+r%0d", r2) : "", hold, pulses, kp.key_code);
      check("rand pulse count", pulses, exp_pulses);
      check("rand key_code", kp.key_code, model_code);
      check("rand held released", kp.key_held, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
